// File: rtl/clk_div_multi_if.sv
// Configuration and status bundle for clk_div_multi.
//   master: drives cfg_we/cfg_ch/cfg_div/cfg_en/sync_i and
//           observes tick_o/sq_o/pend_o/cfg_err_o.
//   slave : the divider block.
interface clk_div_multi_if #(
   parameter int NUM_CH = 4,
   parameter int DIV_W  = 16
);
   localparam int CH_W = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;

   logic              cfg_we;
   logic [CH_W-1:0]   cfg_ch;
   logic [DIV_W-1:0]  cfg_div;
   logic              cfg_en;
   logic              sync_i;
   logic [NUM_CH-1:0] tick_o;
   logic [NUM_CH-1:0] sq_o;
   logic [NUM_CH-1:0] pend_o;
   logic              cfg_err_o;

   modport master (
      output cfg_we, cfg_ch, cfg_div, cfg_en, sync_i,
      input  tick_o, sq_o, pend_o, cfg_err_o
   );

   modport slave (
      input  cfg_we, cfg_ch, cfg_div, cfg_en, sync_i,
      output tick_o, sq_o, pend_o, cfg_err_o
   );
endinterface

// File: rtl/clk_div_multi.sv
// Multi-channel programmable clock divider / baud-tick generator.
// Each channel emits a one-cycle tick every div_act cycles and a square
// wave (low floor(D/2), high ceil(D/2)). Divisor changes on a running
// channel are held pending and applied at the next wrap or sync.
// Ports:
//   clk, reset : system clock, synchronous active-high reset
//   bus (slave): cfg_we/cfg_ch/cfg_div/cfg_en write port, sync_i realign,
//                tick_o/sq_o/pend_o per channel, cfg_err_o reject pulse

// One divider channel. wr is an already-validated write to this channel.
module clk_div_ch #(
   parameter int DIV_W       = 16,
   parameter int DEFAULT_DIV = 2
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             wr,
   input  logic [DIV_W-1:0] cfg_div,
   input  logic             cfg_en,
   input  logic             sync,
   output logic             tick,
   output logic             sq,
   output logic             pend
);
   logic             en_q;
   logic [DIV_W-1:0] cnt;
   logic [DIV_W-1:0] div_act;
   logic [DIV_W-1:0] div_pend;
   logic             pend_v;
   logic             wrap;

   assign wrap = (cnt == div_act - DIV_W'(1));
   assign tick = en_q & wrap;
   assign sq   = en_q & (cnt >= (div_act >> 1));
   assign pend = pend_v;

   always_ff @(posedge clk) begin
      if (reset) begin
         en_q     <= 1'b0;
         cnt      <= '0;
         div_act  <= DIV_W'(DEFAULT_DIV);
         div_pend <= '0;
         pend_v   <= 1'b0;
      end else if (wr && (!en_q || !cfg_en || sync)) begin
         // Stopped channel, disable, or write coinciding with sync:
         // take the new setting immediately and restart the period.
         en_q    <= cfg_en;
         div_act <= cfg_div;
         cnt     <= '0;
         pend_v  <= 1'b0;
      end else if (en_q) begin
         if (sync || wrap) begin
            cnt <= '0;
            if (pend_v) begin
               div_act <= div_pend;
               pend_v  <= 1'b0;
            end
         end else begin
            cnt <= cnt + DIV_W'(1);
         end
         // Placed after the wrap logic so a write on the wrap edge
         // becomes the next pending value.
         if (wr) begin
            div_pend <= cfg_div;
            pend_v   <= 1'b1;
         end
      end
   end
endmodule

module clk_div_multi #(
   parameter int NUM_CH      = 4,
   parameter int DIV_W       = 16,
   parameter int DEFAULT_DIV = 2
) (
   input logic            clk,
   input logic            reset,
   clk_div_multi_if.slave bus
);
   localparam int CH_W = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;
   localparam logic [CH_W:0] NUM_CH_V = (CH_W + 1)'(NUM_CH);

   logic              valid;
   logic              err_q;
   logic [NUM_CH-1:0] tick;
   logic [NUM_CH-1:0] sq;
   logic [NUM_CH-1:0] pend;

   assign valid = bus.cfg_we && ({1'b0, bus.cfg_ch} < NUM_CH_V) &&
                  (bus.cfg_div >= DIV_W'(2));

   always_ff @(posedge clk) begin
      if (reset) err_q <= 1'b0;
      else       err_q <= bus.cfg_we && !valid;
   end

   for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
      clk_div_ch #(.DIV_W(DIV_W), .DEFAULT_DIV(DEFAULT_DIV)) u_ch (
         .clk     (clk),
         .reset   (reset),
         .wr      (valid && (bus.cfg_ch == CH_W'(i))),
         .cfg_div (bus.cfg_div),
         .cfg_en  (bus.cfg_en),
         .sync    (bus.sync_i),
         .tick    (tick[i]),
         .sq      (sq[i]),
         .pend    (pend[i])
      );
   end

   assign bus.tick_o    = tick;
   assign bus.sq_o      = sq;
   assign bus.pend_o    = pend;
   assign bus.cfg_err_o = err_q;
endmodule

// File: tb/tb_clk_div_multi.sv
// Bench for clk_div_multi. Reference model tracks, per channel, the
// absolute cycle of the next tick and the active/pending period; outputs
// are derived from the distance to that next tick.
module tb_clk_div_multi;
   localparam int NCH  = 5;
   localparam int DW   = 8;
   localparam int DDEF = 2;

   logic clk = 1'b0;
   logic reset;
   always #5 clk = ~clk;

   clk_div_multi_if #(.NUM_CH(NCH), .DIV_W(DW)) bus ();

   clk_div_multi #(.NUM_CH(NCH), .DIV_W(DW), .DEFAULT_DIV(DDEF)) dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bus)
   );

   int     tests = 0;
   int     fails = 0;
   longint t = 0;

   bit     m_en [NCH];
   int     m_d  [NCH];
   int     m_pd [NCH];
   bit     m_pv [NCH];
   longint m_next [NCH];
   bit     m_err;

   task automatic check(input string tag, input logic [NCH-1:0] obs,
                        input logic [NCH-1:0] exp);
      tests++;
      assert (obs === exp) else begin
         fails++;
         $error("FAIL %s t=%0d observed=%b expected=%b", tag, t, obs, exp);
      end
   endtask

   // One clock: apply inputs, advance the model, compare all outputs.
   task automatic cyc(input bit we, input int ch, input int dv,
                      input bit en, input bit sy, input bit rs);
      int  chv;
      int  dvv;
      bit  ok;
      logic [NCH-1:0] e_tick, e_sq, e_pend;
      chv = ch & 7;
      dvv = dv & 255;
      reset       = rs;
      bus.cfg_we  = we;
      bus.cfg_ch  = 3'(chv);
      bus.cfg_div = 8'(dvv);
      bus.cfg_en  = en;
      bus.sync_i  = sy;
      @(posedge clk);
      t++;
      ok = we && (chv < NCH) && (dvv >= 2);
      for (int i = 0; i < NCH; i++) begin
         bit w;
         w = ok && (chv == i);
         if (rs) begin
            m_en[i] = 0; m_d[i] = DDEF; m_pd[i] = 0; m_pv[i] = 0;
         end else if (w && (!m_en[i] || !en || sy)) begin
            m_en[i] = en; m_d[i] = dvv; m_pv[i] = 0;
            m_next[i] = t + dvv - 1;
         end else if (m_en[i]) begin
            if (sy || m_next[i] == t - 1) begin
               if (m_pv[i]) begin m_d[i] = m_pd[i]; m_pv[i] = 0; end
               m_next[i] = t + m_d[i] - 1;
            end
            if (w) begin m_pd[i] = dvv; m_pv[i] = 1; end
         end
      end
      m_err = !rs && we && !ok;
      #1;
      for (int i = 0; i < NCH; i++) begin
         e_tick[i] = m_en[i] && (m_next[i] == t);
         e_sq[i]   = m_en[i] && ((m_next[i] - t) < longint'((m_d[i] + 1) / 2));
         e_pend[i] = m_pv[i];
      end
      check("tick", bus.tick_o, e_tick);
      check("sq",   bus.sq_o,   e_sq);
      check("pend", bus.pend_o, e_pend);
      check("err",  {{(NCH-1){1'b0}}, bus.cfg_err_o}, {{(NCH-1){1'b0}}, m_err});
   endtask

   task automatic idle(input int n);
      for (int k = 0; k < n; k++) cyc(0, 0, 0, 0, 0, 0);
   endtask

   initial begin
      // Reset state
      cyc(0, 0, 0, 0, 0, 1);
      cyc(0, 0, 0, 0, 0, 1);
      check("rst_tick", bus.tick_o, '0);
      check("rst_sq",   bus.sq_o,   '0);
      idle(3);

      // ch0 div=4: tick on the 4th cycle after the write, sq 0,0,1,1
      cyc(1, 0, 4, 1, 0, 0);
      idle(12);

      // ch1 div=5 running, retarget to 3 mid-period
      cyc(1, 1, 5, 1, 0, 0);
      idle(2);
      cyc(1, 1, 3, 1, 0, 0);
      check("pend_set", bus.pend_o, 5'b00010);
      idle(12);

      // Rejected writes: div<2 and out-of-range channel
      cyc(1, 2, 1, 1, 0, 0);
      check("err_div", {4'b0, bus.cfg_err_o}, 5'b00001);
      cyc(1, NCH, 7, 1, 0, 0);
      check("err_ch", {4'b0, bus.cfg_err_o}, 5'b00001);
      idle(4);

      // Sync realign: ch0 div=4, ch1 div=6 out of phase
      cyc(1, 1, 6, 0, 0, 0);
      cyc(1, 1, 6, 1, 0, 0);
      idle(3);
      cyc(0, 0, 0, 0, 1, 0);
      idle(26);

      // ch3 div=8, disable, re-enable at div=2
      cyc(1, 3, 8, 1, 0, 0);
      idle(5);
      cyc(1, 3, 8, 0, 0, 0);
      check("dis_sq", bus.sq_o & 5'b01000, '0);
      idle(2);
      cyc(1, 3, 2, 1, 0, 0);
      idle(8);

      // Write on the wrap edge with sync+write coincidence
      cyc(1, 4, 3, 1, 0, 0);
      idle(1);
      cyc(1, 4, 7, 1, 0, 0);
      cyc(1, 4, 9, 1, 1, 0);
      idle(10);
      cyc(1, 4, 255, 1, 0, 0);
      idle(20);

      // Reset mid-count with everything running
      for (int i = 0; i < NCH; i++) cyc(1, i, 3 + i, 1, 0, 0);
      idle(4);
      cyc(0, 0, 0, 0, 0, 1);
      check("mid_rst_tick", bus.tick_o, '0);
      check("mid_rst_sq",   bus.sq_o,   '0);
      idle(10);

      // Randomized traffic
      for (int k = 0; k < 3000; k++) begin
         bit we, en, sy, rs;
         int ch, dv;
         we = ($urandom_range(0, 5) == 0);
         ch = $urandom_range(0, 6);
         dv = ($urandom_range(0, 30) == 0) ? 255 : $urandom_range(0, 12);
         en = ($urandom_range(0, 3) != 0);
         sy = ($urandom_range(0, 40) == 0);
         rs = ($urandom_range(0, 700) == 0);
         cyc(we, ch, dv, en, sy, rs);
      end

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end
endmodule

// File: doc/clk_div_multi.md
Name: clk_div_multi

Overview:
- Parametrised, runtime-programmable multi-channel clock divider / baud-tick generator.
- NUM_CH independent channels share one clk. Each channel has a divisor and enable that software programs through a simple write port.
- Per channel, produces a one-cycle tick strobe (clock-enable for UART TX/RX and pipeline peripherals) and a near-50% square wave.
- Divisor changes on a running channel are glitch-free (applied at wrap). A global sync realigns all channels.

Parameters:
- NUM_CH, 4: number of divider channels (>=1).
- DIV_W, 16: divisor and counter width in bits.
- DEFAULT_DIV, 2: divisor loaded at reset (must be >=2 and <2**DIV_W).
- CH_W (localparam), max(1, $clog2(NUM_CH)): channel index width.

Ports:
- clk  in  1  system clock.
- reset  in  1  reset, synchronous, active-high.
- cfg_we  in  1  config write strobe, one cycle per write.
- cfg_ch  in  CH_W  target channel index.
- cfg_div  in  DIV_W  new divisor (period in clk cycles).
- cfg_en  in  1  new enable state for the channel.
- sync_i  in  1  global phase realign.
- tick_o  out  NUM_CH  per-channel one-cycle strobe, once per period.
- sq_o  out  NUM_CH  per-channel square wave.
- pend_o  out  NUM_CH  divisor change pending (waiting for wrap).
- cfg_err_o  out  1  registered one-cycle pulse on a rejected write.

Behaviour:
- Per-channel registers: en_q, cnt[DIV_W], div_act[DIV_W], div_pend[DIV_W], pend_v.
- Reset values:
  - en_q=0, cnt=0, div_act=DEFAULT_DIV, div_pend=0, pend_v=0, cfg_err_o=0.
  - Hence tick_o=0, sq_o=0, pend_o=0.
- Outputs are combinational from registers only, with no input-to-output path:
  - tick_o[i] = en_q & (cnt == div_act-1)
  - sq_o[i] = en_q & (cnt >= div_act>>1)
  - pend_o[i] = pend_v
- Counting, per edge with en_q=1 and no sync/cfg to that channel:
  - cnt == div_act-1: cnt<=0. If pend_v: div_act<=div_pend and pend_v<=0.
  - Otherwise: cnt<=cnt+1.
- Counting when en_q=0: cnt held at 0.
- Resulting waveforms:
  - Tick period is exactly div_act cycles.
  - sq_o is low for floor(D/2) cycles and high for ceil(D/2) cycles. D=4 gives 2/2; D=5 gives 2 low, 3 high.
- Config write (cfg_we=1):
  - Reject when cfg_ch >= NUM_CH or cfg_div < 2. The write is ignored, with no state change, and cfg_err_o=1 on the next cycle.
  - Channel currently disabled, or cfg_en=0: en_q<=cfg_en, div_act<=cfg_div, cnt<=0, pend_v<=0. The change is immediate.
  - Channel enabled and cfg_en=1: div_pend<=cfg_div, pend_v<=1, and counting continues. The new divisor takes effect at the next wrap. A second write before the wrap overwrites div_pend.
  - A newly enabled channel's first tick occurs div-1 cycles after the write edge, i.e. the div-th cycle after the write.
- sync_i=1 at an edge:
  - For every enabled channel: cnt<=0. If pend_v, div_act<=div_pend and pend_v<=0.
  - Disabled channels are unaffected.
- sync_i and cfg_we in the same cycle:
  - Non-targeted channels follow the sync rule.
  - Targeted channel with a valid write: div_act<=cfg_div, cnt<=0, pend_v<=0, en_q<=cfg_en (immediate apply).
  - A rejected write still applies sync to all channels.
- Simultaneous wrap and cfg write to the same running channel: the wrap applies the old pending value (if any), and the new cfg_div becomes pending.
- Reset mid-operation: all channels return to reset values on that edge, and outputs go low in the next cycle.
- Widths:
  - cnt compares use DIV_W bits; there is no overflow, since cnt <= div_act-1 < 2**DIV_W.
  - Max divisor is 2**DIV_W-1.

Test Plan:
- Reset, then write ch0 div=4 en=1 -> tick_o[0] pulses every 4 cycles, first on the 4th cycle after the write; sq_o[0]=0,0,1,1 repeating; other channels stay 0.
- ch1 div=5 running; write ch1 div=3 mid-period -> pend_o[1]=1 until the current 5-cycle period ends; the next periods are 3 cycles; pend_o[1] clears on the wrap edge.
- Write ch2 div=1, then write cfg_ch=NUM_CH -> cfg_err_o pulses one cycle each time; the ch2 state is unchanged (still disabled, div_act=2).
- ch0 div=4, ch1 div=6 both running out of phase; assert sync_i one cycle -> both cnt=0; ticks coincide 4 and 6 cycles later respectively, then every 12 cycles jointly.
- Running ch3 div=8: write cfg_en=0 -> tick_o[3]/sq_o[3] low the next cycle; re-enable with div=2 -> tick every 2 cycles, sq_o[3] toggling 0,1.
- Assert reset mid-count with all channels enabled -> all outputs 0 the next cycle; div_act returns to DEFAULT_DIV; no ticks until reprogrammed.
